// File: rtl/windower_frame_ctrl.sv
// windower_frame_ctrl: cuts a ready/valid sample stream into frames of
// 2**LOG2_IMG_SIZE samples for the windower. After each frame an idle gap
// lets the windower drain its padding tail. Its vld_out pulses are counted
// per frame and compared with OUT_PER_FRAME. A job runs num_frames frames.
module windower_frame_ctrl #(
  parameter int NO_CH         = 16,
  parameter int LOG2_IMG_SIZE = 6,
  parameter int THROUGHPUT    = 1,
  parameter int WINDOW        = 5,
  parameter int PADDING       = 1,
  parameter int FLUSH_CYC     = 8,
  parameter int OUT_PER_FRAME = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [7:0]                  num_frames,
  input  logic                        abort,
  input  logic                        src_vld,
  output logic                        src_rdy,
  input  logic [NO_CH*THROUGHPUT-1:0] src_data,
  output logic                        win_vld_in,
  output logic [NO_CH*THROUGHPUT-1:0] win_data_in,
  input  logic                        win_vld_out,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        done,
  output logic                        err
);

  localparam int IMG_SIZE = 1 << LOG2_IMG_SIZE;
  localparam int BEATS    = IMG_SIZE / THROUGHPUT;
  localparam int BEAT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int FLUSH_W  = $clog2(FLUSH_CYC + 1);
  localparam int CNT_W    = $clog2(OUT_PER_FRAME) + 2;

  // An illegal configuration (throughput not dividing the frame, no drain
  // gap, meaningless windower geometry) leaves the block permanently unready.
  localparam bit CFG_OK = (THROUGHPUT > 0) && ((IMG_SIZE % THROUGHPUT) == 0) &&
                          (FLUSH_CYC >= 1) && (WINDOW >= 1) && (PADDING >= 0);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_next;
  logic [7:0]           frames_left_r;
  logic [BEAT_W-1:0]    beat_cnt_r;
  logic [FLUSH_W-1:0]   flush_cnt_r;
  logic [CNT_W-1:0]     out_cnt_r;
  logic [CNT_W-1:0]     out_cnt_inc_s;
  logic                 accept_s;
  logic                 last_beat_s;
  logic                 flush_end_s;
  logic                 start_ok_s;

  // Saturating +1 so a runaway windower cannot wrap the count back to a
  // plausible value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                                input logic             inc);
    if (inc && (cnt != {CNT_W{1'b1}})) begin
      sat_inc = cnt + CNT_W'(1);
    end else begin
      sat_inc = cnt;
    end
  endfunction

  // Upstream may only hand over beats while a frame is being streamed.
  assign src_rdy = (state_r == ST_STREAM) && CFG_OK;

  // Next-state and per-cycle control decisions.
  always_comb begin
    state_next    = state_r;
    accept_s      = 1'b0;
    last_beat_s   = 1'b0;
    flush_end_s   = 1'b0;
    start_ok_s    = 1'b0;
    out_cnt_inc_s = sat_inc(out_cnt_r, win_vld_out);
    case (state_r)
      ST_IDLE: begin
        if (start && !abort) begin
          start_ok_s = 1'b1;
          if (num_frames != 8'd0) begin
            state_next = ST_STREAM;
          end else begin
            state_next = ST_DONE;
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_STREAM: begin
        last_beat_s = (beat_cnt_r == BEAT_W'(BEATS - 1));
        if (abort) begin
          state_next = ST_IDLE;
        end else if (src_vld && src_rdy) begin
          accept_s = 1'b1;
          if (last_beat_s) begin
            state_next = ST_FLUSH;
          end else begin
            state_next = ST_STREAM;
          end
        end else begin
          state_next = ST_STREAM;
        end
      end
      ST_FLUSH: begin
        if (abort) begin
          state_next = ST_IDLE;
        end else if (flush_cnt_r == FLUSH_W'(FLUSH_CYC - 1)) begin
          flush_end_s = 1'b1;
          if (frames_left_r == 8'd1) begin
            state_next = ST_DONE;
          end else begin
            state_next = ST_STREAM;
          end
        end else begin
          state_next = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // State register and registered status / windower-side outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_done  <= 1'b0;
      win_vld_in  <= 1'b0;
      win_data_in <= '0;
    end else begin
      state_r    <= state_next;
      busy       <= (state_next != ST_IDLE);
      done       <= (state_next == ST_DONE);
      frame_done <= flush_end_s;
      win_vld_in <= accept_s;
      if (accept_s) begin
        win_data_in <= src_data;
      end else begin
        win_data_in <= win_data_in;
      end
    end
  end

  // Beat, flush, output and frame counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      frames_left_r <= 8'd0;
      beat_cnt_r    <= '0;
      flush_cnt_r   <= '0;
      out_cnt_r     <= '0;
    end else if (start_ok_s) begin
      frames_left_r <= num_frames;
      beat_cnt_r    <= '0;
      flush_cnt_r   <= '0;
      out_cnt_r     <= '0;
    end else if ((state_next == ST_IDLE) || (state_r == ST_DONE)) begin
      frames_left_r <= 8'd0;
      beat_cnt_r    <= '0;
      flush_cnt_r   <= '0;
      out_cnt_r     <= '0;
    end else if (state_r == ST_STREAM) begin
      out_cnt_r <= out_cnt_inc_s;
      if (accept_s && last_beat_s) begin
        beat_cnt_r  <= '0;
        flush_cnt_r <= '0;
      end else if (accept_s) begin
        beat_cnt_r <= beat_cnt_r + BEAT_W'(1);
      end else begin
        beat_cnt_r <= beat_cnt_r;
      end
    end else if (state_r == ST_FLUSH) begin
      if (flush_end_s) begin
        frames_left_r <= frames_left_r - 8'd1;
        beat_cnt_r    <= '0;
        flush_cnt_r   <= '0;
        out_cnt_r     <= '0;
      end else begin
        flush_cnt_r <= flush_cnt_r + FLUSH_W'(1);
        out_cnt_r   <= out_cnt_inc_s;
      end
    end else begin
      frames_left_r <= frames_left_r;
    end
  end

  // Sticky error: cleared by an accepted start, set by a bad frame count
  // (the windower pulse of the frame's final flush cycle is included).
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (start_ok_s) begin
      err <= 1'b0;
    end else if (flush_end_s && (out_cnt_inc_s != CNT_W'(OUT_PER_FRAME))) begin
      err <= 1'b1;
    end else begin
      err <= err;
    end
  end

endmodule
